// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC channel scheduler: state encoding,
// converter data width and parameter defaults.
package adc_sched_pkg;

  localparam int unsigned ADC_BITS              = 4;
  localparam int unsigned NCH_DEFAULT           = 4;
  localparam int unsigned SAMPLE_CYCLES_DEFAULT = 2;
  localparam int unsigned CONV_CYCLES_DEFAULT   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_RESULT  = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after index ptr, ascending with wrap, and returns it one-hot.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [NCH-1:0]         grant
);

  localparam int unsigned IW = $clog2(NCH);

  logic        found;
  int unsigned idx;

  // Scan NCH positions starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(ptr) + i) % NCH;
      if (!found && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Schedules multi-channel SAR conversions: round-robin channel pick, a
// track/hold sample phase, a timed SAR conversion phase and a held result
// presented on a valid/ready channel.
module adc_channel_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned NCH           = NCH_DEFAULT,
  parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_DEFAULT,
  parameter int unsigned CONV_CYCLES   = CONV_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rstp,
  input  logic [NCH-1:0]         req,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] ch_sel,
  output logic                   sample_en,
  output logic                   sar_rstp,
  input  logic [ADC_BITS-1:0]    sar_adc_out,
  output logic [ADC_BITS-1:0]    res_data,
  output logic [$clog2(NCH)-1:0] res_ch,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(NCH);
  localparam int unsigned CW = $clog2(max_u(SAMPLE_CYCLES, CONV_CYCLES)) + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NCH-1:0]      grant_q, grant_d;
  logic [IW-1:0]       ch_sel_q, ch_sel_d;
  logic                sample_en_q, sample_en_d;
  logic                sar_rstp_q, sar_rstp_d;
  logic [ADC_BITS-1:0] res_data_q, res_data_d;
  logic [IW-1:0]       res_ch_q, res_ch_d;
  logic                res_valid_q, res_valid_d;
  logic                busy_q, busy_d;

  logic [NCH-1:0]      arb_grant;
  logic [IW-1:0]       arb_sel;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // One-hot to binary index of the arbiter's pick.
  always_comb begin
    arb_sel = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (arb_grant[IW'(j)]) arb_sel = IW'(j);
    end
  end

  // Next-state, counter, result capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ch_sel_d   = ch_sel_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_SAMPLE;
          grant_d  = arb_grant;
          ch_sel_d = arb_sel;
          cnt_d    = '0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CONVERT: begin
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d    = ST_RESULT;
          cnt_d      = '0;
          res_data_d = sar_adc_out;
          res_ch_d   = ch_sel_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          grant_d = '0;
          // Pointer holds the next search start, i.e. served index + 1.
          ptr_d   = (ch_sel_q == IW'(NCH - 1)) ? '0 : ch_sel_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    sample_en_d = (state_d == ST_SAMPLE);
    sar_rstp_d  = (state_d != ST_CONVERT);
    res_valid_d = (state_d == ST_RESULT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      ch_sel_q    <= '0;
      sample_en_q <= 1'b0;
      sar_rstp_q  <= 1'b1;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ch_sel_q    <= ch_sel_d;
      sample_en_q <= sample_en_d;
      sar_rstp_q  <= sar_rstp_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign ch_sel    = ch_sel_q;
  assign sample_en = sample_en_q;
  assign sar_rstp  = sar_rstp_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with default parameters.
module tb_adc_channel_scheduler;

  logic       clk;
  logic       rstp;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] ch_sel;
  logic       sample_en;
  logic       sar_rstp;
  logic [3:0] sar_adc_out;
  logic [3:0] res_data;
  logic [1:0] res_ch;
  logic       res_valid;
  logic       res_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  adc_channel_scheduler #(
    .NCH           (4),
    .SAMPLE_CYCLES (2),
    .CONV_CYCLES   (5)
  ) dut (
    .clk         (clk),
    .rstp        (rstp),
    .req         (req),
    .grant       (grant),
    .ch_sel      (ch_sel),
    .sample_en   (sample_en),
    .sar_rstp    (sar_rstp),
    .sar_adc_out (sar_adc_out),
    .res_data    (res_data),
    .res_ch      (res_ch),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an IDLE sample point, run one conversion and stop at the first
  // RESULT cycle. gap = edges until busy (1 = one IDLE cycle seen).
  task automatic run_conv(input int ch, input logic [3:0] d, input int gap, input bit drop);
    int n;
    int s;
    int c;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("idle_gap", n, gap);
    check("grant", grant, 32'(4'b0001 << ch));
    check("ch_sel", ch_sel, ch);
    check("sar_rstp_sample", sar_rstp, 1);
    if (drop) req = '0;
    s = 0;
    while (sample_en && s < 20) begin
      s++;
      tick();
    end
    check("sample_len", s, 2);
    c = 0;
    while (!sar_rstp && c < 20) begin
      check("conv_sample_en", sample_en, 0);
      c++;
      tick();
    end
    check("conv_len", c, 5);
    check("res_valid", res_valid, 1);
    check("res_data", res_data, d);
    check("res_ch", res_ch, ch);
    check("sar_rstp_result", sar_rstp, 1);
  endtask

  // Handshake edge with res_ready already high; expect IDLE afterwards.
  task automatic handshake();
    tick();
    check("hs_valid", res_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_grant", grant, 0);
    check("hs_sar_rstp", sar_rstp, 1);
  endtask

  initial begin
    rstp        = 1'b1;
    req         = '0;
    sar_adc_out = '0;
    res_ready   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_grant", grant, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_sample_en", sample_en, 0);
    check("rst_sar_rstp", sar_rstp, 1);
    check("rst_res_data", res_data, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);

    // Single request on channel 2
    rstp        = 1'b0;
    req         = 4'b0100;
    sar_adc_out = 4'hB;
    res_ready   = 1'b1;
    run_conv(2, 4'hB, 1, 1'b0);
    req = '0;
    handshake();
    tick();
    check("single_stay_idle", busy, 0);

    // Abort on the 3rd CONVERT cycle (ptr currently 3; reset must clear it)
    req = 4'b0010;
    tick();
    check("abort_grant", grant, 4'b0010);
    repeat (4) tick();
    check("abort_in_conv", sar_rstp, 0);
    check("abort_busy_pre", busy, 1);
    rstp = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_sar_rstp", sar_rstp, 1);
    check("abort_grant_clr", grant, 0);
    rstp = 1'b0;

    // Fairness with all requests held: 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      sar_adc_out = 4'(i + 5);
      run_conv(i % 4, 4'(i + 5), 1, 1'b0);
      handshake();
    end
    req = '0;
    tick();
    check("fair_idle", busy, 0);

    // Back-pressure on channel 3 (ptr now 1)
    req         = 4'b1000;
    res_ready   = 1'b0;
    sar_adc_out = 4'h6;
    run_conv(3, 4'h6, 1, 1'b0);
    req = '0;
    for (int k = 0; k < 10; k++) begin
      sar_adc_out = 4'(k * 3 + 1);
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 4'h6);
      check("bp_ch", res_ch, 3);
    end
    res_ready = 1'b1;
    handshake();

    // Dropped request: req[1] released during SAMPLE (ptr now 0)
    req         = 4'b0010;
    sar_adc_out = 4'h9;
    run_conv(1, 4'h9, 1, 1'b1);
    handshake();
    tick();
    check("drop_stay_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_channel_scheduler.md
ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels (2..8).
REQ-002 Parameter SAMPLE_CYCLES, default 2: track/hold sample phase length in clocks (>=1).
REQ-003 Parameter CONV_CYCLES, default 5: clocks the SAR comparison module is released per conversion (>=4).
REQ-004 Clocking SHALL be one clock with synchronous, active-high reset: clk input 1, rising-edge clock; rstp input 1, synchronous active-high reset.
REQ-005 req  input  NCH  per-channel conversion request, level-sensitive.
REQ-006 grant  output  NCH  one-hot channel currently being served; all-zero when none.
REQ-007 ch_sel  output  clog2(NCH)  analog input mux select, binary index of the granted channel.
REQ-008 sample_en  output  1  track/hold switch enable.
REQ-009 sar_rstp  output  1  drives rstp of the SAR comparison module; high holds the SAR in reset.
REQ-010 sar_adc_out  input  4  conversion result from the SAR comparison module.
REQ-011 res_data  output  4, res_ch  output  clog2(NCH), res_valid  output  1, res_ready  input  1: result channel with valid/ready handshake.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SAMPLE, CONVERT and RESULT only.
REQ-014 IDLE: when any req bit is 1 at a clk edge, the block SHALL select one channel round-robin, load grant/ch_sel and enter SAMPLE at that edge.
REQ-015 Round-robin: the search starts at index (last served + 1) mod NCH, ascending with wrap; after reset the search starts at index 0.
REQ-016 SAMPLE: sample_en=1, sar_rstp=1 for exactly SAMPLE_CYCLES clocks, then CONVERT.
REQ-017 CONVERT: sample_en=0, sar_rstp=0 for exactly CONV_CYCLES clocks; on the final CONVERT edge, sar_adc_out SHALL be latched into res_data, ch_sel into res_ch, and the FSM SHALL enter RESULT.
REQ-018 Latency: with req captured at edge T0, res_valid SHALL first be 1 in the cycle after edge T0+SAMPLE_CYCLES+CONV_CYCLES (defaults: 7 edges).
REQ-019 RESULT: res_valid=1, sar_rstp=1, sample_en=0; res_data and res_ch SHALL remain stable until the handshake.
REQ-020 Handshake completes on an edge where res_valid=1 and res_ready=1; that edge clears res_valid and grant, records the served index, and returns to IDLE; res_ready=1 on the first RESULT cycle SHALL be accepted.
REQ-021 A channel can be served again only after one IDLE cycle following its handshake; no RESULT-to-SAMPLE bypass.
REQ-022 Deassertion of the granted req during SAMPLE or CONVERT SHALL NOT abort the conversion; the result is still delivered.
REQ-023 req changes outside IDLE SHALL be ignored until the next IDLE arbitration.
REQ-024 res_ready while res_valid=0 SHALL have no effect.
REQ-025 Back-pressure of any duration in RESULT SHALL NOT lose or alter the result.
REQ-026 Counter SHALL be ceil(log2(max(SAMPLE_CYCLES,CONV_CYCLES)))+1 bits, cleared on every state entry; no wrap SHALL occur.

Reset
REQ-027 rstp=1 at any edge, including mid-conversion or mid-RESULT, SHALL force IDLE and drop any pending result.
REQ-028 Reset values: grant=0, ch_sel=0, sample_en=0, sar_rstp=1, res_data=0, res_ch=0, res_valid=0, busy=0, round-robin pointer=0.
REQ-029 sar_rstp SHALL be 1 in IDLE, SAMPLE, RESULT and during reset.

Structure
REQ-030 Package adc_sched_pkg SHALL hold the state encodings, ADC_BITS=4 and the parameter defaults.
REQ-031 Arbitration SHALL be a sub-module rr_arbiter (req, pointer in, one-hot grant out, combinational); the FSM, counter and result register stay in the top module.

Verification
REQ-032 Reset: rstp=1 for 3 cycles -> sar_rstp=1, all other outputs 0, busy=0.
REQ-033 Single request: req=4'b0100, sar_adc_out=4'hB, res_ready=1 -> grant=4'b0100, ch_sel=2, SAMPLE 2 cycles, CONVERT 5 cycles, then res_data=4'hB, res_ch=2 for one cycle.
REQ-034 Fairness: req=4'b1111 held, res_ready=1 -> served order 0,1,2,3,0, each separated by exactly one IDLE cycle.
REQ-035 Back-pressure: res_ready=0 for 10 cycles in RESULT -> res_valid, res_data, res_ch stable; sar_adc_out changes ignored; handshake on res_ready=1 then IDLE.
REQ-036 Abort: rstp=1 on the 3rd CONVERT cycle -> next cycle IDLE, res_valid=0, sar_rstp=1, next arbitration starts at channel 0.
REQ-037 Dropped request: req[1] deasserted during SAMPLE -> conversion completes, res_ch=1 delivered.
